// File: rtl/spi_vector_receiver.sv
// Deserialises SPI vector frames into a pending buffer and commits them to the core on vblank.
// Latency: commit visible the cycle after the strobe edge; no backpressure, a newer frame overwrites the pending one.
module spi_vector_receiver #(
   parameter int         VEC_W           = 16,
   parameter logic [7:0] CMD_SET_VECTORS = 8'h01,
   parameter logic [7:0] CMD_NOP         = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_sclk,
   input  logic             i_mosi,
   input  logic             i_ss_n,
   input  logic             i_vblank_strobe,
   output logic [VEC_W-1:0] new_playerX,
   output logic [VEC_W-1:0] new_playerY,
   output logic [VEC_W-1:0] new_facingX,
   output logic [VEC_W-1:0] new_facingY,
   output logic [VEC_W-1:0] new_vplaneX,
   output logic [VEC_W-1:0] new_vplaneY,
   output logic             write_new_position,
   output logic             o_overrun,
   output logic [7:0]       o_frame_count
);

   localparam int SHREG_W = 8 + 6 * VEC_W;
   localparam logic [6:0] LAST_BIT = 7'(SHREG_W - 1);

   typedef struct packed {
      logic [VEC_W-1:0] player_x;
      logic [VEC_W-1:0] player_y;
      logic [VEC_W-1:0] facing_x;
      logic [VEC_W-1:0] facing_y;
      logic [VEC_W-1:0] vplane_x;
      logic [VEC_W-1:0] vplane_y;
   } vec_t;

   typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, DONE, DISCARD} state_t;

   logic sclk_s1, sclk_s2, sclk_s3;
   logic ss_s1, ss_s2, ss_s3;
   logic mosi_s1, mosi_s2;
   logic sclk_rise, ss_rise, ss_fall;
   logic [1:0] warm_cnt;
   logic ss_armed;

   state_t state_q, state_d;
   logic [6:0] bit_cnt;
   logic [SHREG_W-1:0] shreg;
   logic [7:0] cmd_byte;
   logic shift_en, cnt_clr, frame_done, commit;

   vec_t pending_dat, out_dat;
   logic pending_vld;

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
         ss_s1   <= 1'b1; ss_s2   <= 1'b1; ss_s3   <= 1'b1;
         mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
      end else begin
         sclk_s1 <= i_sclk;  sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
         ss_s1   <= i_ss_n;  ss_s2   <= ss_s1;   ss_s3   <= ss_s2;
         mosi_s1 <= i_mosi;  mosi_s2 <= mosi_s1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   assign ss_rise   = ss_s2 & ~ss_s3;
   assign ss_fall   = ~ss_s2 & ss_s3;

   // The reset values of the ss_n chain would fake a falling edge if ss_n is held low
   // through reset, so a frame may only start once the flushed chain has shown ss_n high.
   always_ff @(posedge clk) begin
      if (reset) begin
         warm_cnt <= 2'd0;
         ss_armed <= 1'b0;
      end else begin
         if (warm_cnt != 2'd3)
            warm_cnt <= warm_cnt + 2'd1;
         if (warm_cnt == 2'd3 && ss_s2 && ss_s3)
            ss_armed <= 1'b1;
      end
   end

   assign cmd_byte = {shreg[6:0], mosi_s2};

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      shift_en   = 1'b0;
      cnt_clr    = 1'b0;
      frame_done = 1'b0;
      if (state_q != IDLE && ss_rise) begin
         state_d    = IDLE;
         frame_done = (state_q == DONE);
      end else begin
         case (state_q)
            IDLE: begin
               if (ss_fall && ss_armed) begin
                  state_d = CMD;
                  cnt_clr = 1'b1;
               end
            end
            CMD: begin
               if (sclk_rise) begin
                  shift_en = 1'b1;
                  if (bit_cnt == 7'd7) begin
                     case (cmd_byte)
                        CMD_SET_VECTORS: state_d = PAYLOAD;
                        CMD_NOP:         state_d = DISCARD;
                        default:         state_d = DISCARD;
                     endcase
                  end
               end
            end
            PAYLOAD: begin
               if (sclk_rise) begin
                  shift_en = 1'b1;
                  if (bit_cnt == LAST_BIT)
                     state_d = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt <= 7'd0;
         shreg   <= '0;
      end else if (cnt_clr) begin
         bit_cnt <= 7'd0;
      end else if (shift_en) begin
         bit_cnt <= bit_cnt + 7'd1;
         shreg   <= {shreg[SHREG_W-2:0], mosi_s2};
      end
   end

   assign commit = i_vblank_strobe & pending_vld;

   // On a coincident frame and strobe, the old pending value commits and the new one stays pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_dat        <= '0;
         pending_vld        <= 1'b0;
         out_dat            <= '0;
         write_new_position <= 1'b0;
         o_overrun          <= 1'b0;
         o_frame_count      <= 8'd0;
      end else begin
         write_new_position <= commit;
         if (commit)
            out_dat <= pending_dat;
         if (frame_done) begin
            pending_dat   <= vec_t'(shreg[6*VEC_W-1:0]);
            pending_vld   <= 1'b1;
            o_frame_count <= o_frame_count + 8'd1;
            if (pending_vld && !i_vblank_strobe)
               o_overrun <= 1'b1;
         end else if (commit) begin
            pending_vld <= 1'b0;
         end
      end
   end

   assign new_playerX = out_dat.player_x;
   assign new_playerY = out_dat.player_y;
   assign new_facingX = out_dat.facing_x;
   assign new_facingY = out_dat.facing_y;
   assign new_vplaneX = out_dat.vplane_x;
   assign new_vplaneY = out_dat.vplane_y;

endmodule
